// File: rtl/regfile_rd_arbiter_pkg.sv
// Shared constants for the register-file read arbiter: default sizes, the
// register address width and the requester-id width helper.
package regfile_arb_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 32;
  localparam int AW        = 5;
  localparam int NREG      = 32;

  // Keeps the id field at least one bit wide when only one requester exists.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_rd_arbiter_if.sv
// Bundle of requester, external-mux and read-return signals around the
// register-file read arbiter. The master side is the requesters plus mux.
interface regfile_rd_arbiter_if import regfile_arb_pkg::*; #(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) ();

  localparam int IDW = id_width(NREQ);

  // Handshake: requester i holds req[i] and its addr slice stable until it
  // sees gnt[i] high in the same cycle, which is the transfer cycle; hold
  // high withholds every grant. The read returns two cycles later as a
  // one-cycle rd_valid push tagged with rd_id; there is no back-pressure.
  logic [NREQ-1:0]    req;
  logic [AW*NREQ-1:0] addr;
  logic               hold;
  logic [NREQ-1:0]    gnt;
  logic [AW-1:0]      sel;
  logic [WIDTH-1:0]   mux_out;
  logic [WIDTH-1:0]   rd_data;
  logic               rd_valid;
  logic [IDW-1:0]     rd_id;

  modport master (
    output req, addr, hold, mux_out,
    input  gnt, sel, rd_data, rd_valid, rd_id
  );

  modport slave (
    input  req, addr, hold, mux_out,
    output gnt, sel, rd_data, rd_valid, rd_id
  );

endinterface

// File: rtl/regfile_rd_arbiter_rr.sv
// Round-robin picker: the first asserted request at or after ptr wins,
// reported both one-hot and as an encoded index.
module rr_arbiter import regfile_arb_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  int             j;
  logic [IDW-1:0] jj;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    jj  = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      jj = IDW'(j);
      if (!any && req[jj]) begin
        any     = 1'b1;
        gnt[jj] = 1'b1;
        idx     = jj;
      end
    end
  end

endmodule

// File: rtl/regfile_rd_arbiter.sv
// Shares one external 32:1 register read mux between NREQ requesters:
// round-robin grant, registered select, registered result two cycles later.
module regfile_rd_arbiter import regfile_arb_pkg::*; #(
  parameter int NREQ    = NREQ_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  parameter bit R0_ZERO = 1'b1
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_rd_arbiter_if.slave bus
);

  localparam int IDW = id_width(NREQ);

  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  win_idx;
  logic [NREQ-1:0] rr_gnt;
  logic            rr_any;
  logic            grant;
  logic [AW-1:0]   addr_arr [NREQ];
  logic [AW-1:0]   win_addr;

  logic [AW-1:0]   sel_q;
  logic            s1_valid;
  logic [IDW-1:0]  s1_id;
  logic [WIDTH-1:0] rd_data_q;
  logic            rd_valid_q;
  logic [IDW-1:0]  rd_id_q;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req (bus.req),
    .ptr (ptr),
    .gnt (rr_gnt),
    .idx (win_idx),
    .any (rr_any)
  );

  for (genvar i = 0; i < NREQ; i++) begin : g_addr
    assign addr_arr[i] = bus.addr[i*AW +: AW];
  end

  // Grant is withheld during reset so nothing leaks out before state is sane.
  assign grant    = rst_n && !bus.hold && rr_any;
  assign win_addr = addr_arr[win_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant) begin
      ptr <= (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
    end
  end

  // Stage 1: drive the external mux select and remember who asked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q    <= '0;
      s1_valid <= 1'b0;
      s1_id    <= '0;
    end else begin
      s1_valid <= grant;
      if (grant) begin
        sel_q <= win_addr;
        s1_id <= win_idx;
      end
    end
  end

  // Stage 2: capture the mux data; register 0 may be forced to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_id_q    <= '0;
    end else begin
      rd_valid_q <= s1_valid;
      if (s1_valid) begin
        rd_id_q   <= s1_id;
        rd_data_q <= (R0_ZERO && sel_q == '0) ? '0 : bus.mux_out;
      end
    end
  end

  assign bus.gnt      = grant ? rr_gnt : '0;
  assign bus.sel      = sel_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_id    = rd_id_q;

endmodule

// File: tb/tb_regfile_rd_arbiter.sv
// Bench for regfile_rd_arbiter: two copies (R0_ZERO=1 and 0) share stimulus,
// each backed by a modelled register file acting as the external mux.
module tb_regfile_rd_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  req;
  logic [19:0] addr;
  logic        hold;
  logic [31:0] rf [32];

  logic [33:0] exp_a_q[$];
  logic [33:0] exp_b_q[$];
  int pass_cnt  = 0;
  int total_cnt = 0;
  int model_ptr = 0;

  regfile_rd_arbiter_if #(.NREQ(4), .WIDTH(32)) bus_a ();
  regfile_rd_arbiter_if #(.NREQ(4), .WIDTH(32)) bus_b ();

  assign bus_a.req     = req;
  assign bus_a.addr    = addr;
  assign bus_a.hold    = hold;
  assign bus_a.mux_out = rf[bus_a.sel];
  assign bus_b.req     = req;
  assign bus_b.addr    = addr;
  assign bus_b.hold    = hold;
  assign bus_b.mux_out = rf[bus_b.sel];

  regfile_rd_arbiter #(.NREQ(4), .WIDTH(32), .R0_ZERO(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave)
  );
  regfile_rd_arbiter #(.NREQ(4), .WIDTH(32), .R0_ZERO(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    hold  = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic push_read(input int id, input logic [4:0] a);
    logic [31:0] d;
    d = rf[a];
    exp_a_q.push_back({2'(id), (a == 5'd0) ? 32'h0 : d});
    exp_b_q.push_back({2'(id), d});
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 10 && (exp_a_q.size() != 0 || exp_b_q.size() != 0); i++) step();
    total_cnt++;
    if (exp_a_q.size() != 0 || exp_b_q.size() != 0)
      $display("FAIL %s_drain pending a=%0d b=%0d required 0", name, exp_a_q.size(), exp_b_q.size());
    else pass_cnt++;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [33:0] e;
    if (bus_a.rd_valid) begin
      total_cnt++;
      if (exp_a_q.size() == 0) begin
        $display("FAIL rd_a_unexpected id=%0d data=%h required no read", bus_a.rd_id, bus_a.rd_data);
      end else begin
        e = exp_a_q.pop_front();
        if ({bus_a.rd_id, bus_a.rd_data} !== e)
          $display("FAIL rd_a id/data=%0d/%h required %0d/%h", bus_a.rd_id, bus_a.rd_data, e[33:32], e[31:0]);
        else pass_cnt++;
      end
    end
    if (bus_b.rd_valid) begin
      total_cnt++;
      if (exp_b_q.size() == 0) begin
        $display("FAIL rd_b_unexpected id=%0d data=%h required no read", bus_b.rd_id, bus_b.rd_data);
      end else begin
        e = exp_b_q.pop_front();
        if ({bus_b.rd_id, bus_b.rd_data} !== e)
          $display("FAIL rd_b id/data=%0d/%h required %0d/%h", bus_b.rd_id, bus_b.rd_data, e[33:32], e[31:0]);
        else pass_cnt++;
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'hF;
    hold  = 1'b0;
    addr  = '0;
    #2;
    total_cnt++;
    if (bus_a.gnt !== 4'b0 || bus_a.sel !== 5'd0 || bus_a.rd_valid !== 1'b0 ||
        bus_a.rd_data !== 32'h0 || bus_a.rd_id !== 2'd0)
      $display("FAIL reset_a gnt=%b sel=%0d v=%b data=%h id=%0d required all zero",
               bus_a.gnt, bus_a.sel, bus_a.rd_valid, bus_a.rd_data, bus_a.rd_id);
    else pass_cnt++;
    total_cnt++;
    if (bus_b.gnt !== 4'b0 || bus_b.sel !== 5'd0 || bus_b.rd_valid !== 1'b0)
      $display("FAIL reset_b gnt=%b sel=%0d v=%b required all zero", bus_b.gnt, bus_b.sel, bus_b.rd_valid);
    else pass_cnt++;
    req = '0;
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      total_cnt++;
      if (bus_a.gnt !== 4'b0 || bus_a.rd_valid !== 1'b0 || bus_a.sel !== 5'd0)
        $display("FAIL idle_after_reset cyc=%0d gnt=%b v=%b sel=%0d required 0/0/0",
                 c, bus_a.gnt, bus_a.rd_valid, bus_a.sel);
      else pass_cnt++;
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_g;
    do_reset();
    for (int i = 0; i < 4; i++) addr[i*5 +: 5] = 5'(8 + i);
    for (int k = 0; k < 8; k++) begin
      step();
      req  = 4'hF;
      hold = 1'b0;
      #1;
      exp_g = 4'b0001 << (k % 4);
      total_cnt++;
      if (bus_a.gnt !== exp_g) $display("FAIL fairness_gnt k=%0d got %b required %b", k, bus_a.gnt, exp_g);
      else pass_cnt++;
      push_read(k % 4, 5'(8 + k % 4));
    end
    step();
    req = '0;
    drain("fairness");
  endtask

  task automatic test_single();
    step();
    req = 4'b0001;
    addr[4:0] = 5'd5;
    hold = 1'b0;
    #1;
    total_cnt++;
    if (bus_a.gnt !== 4'b0001) $display("FAIL single_gnt got %b required 0001", bus_a.gnt);
    else pass_cnt++;
    push_read(0, 5'd5);
    step();
    req = '0;
    #1;
    total_cnt++;
    if (bus_a.sel !== 5'd5 || bus_a.gnt !== 4'b0)
      $display("FAIL single_sel sel=%0d gnt=%b required 5/0000", bus_a.sel, bus_a.gnt);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus_a.rd_valid !== 1'b1 || bus_a.rd_data !== 32'hDEADBEEF || bus_a.rd_id !== 2'd0)
      $display("FAIL single_rd v=%b data=%h id=%0d required 1/deadbeef/0",
               bus_a.rd_valid, bus_a.rd_data, bus_a.rd_id);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus_a.rd_valid !== 1'b0 || bus_a.sel !== 5'd5)
      $display("FAIL single_idle v=%b sel=%0d required 0/5", bus_a.rd_valid, bus_a.sel);
    else pass_cnt++;
    drain("single");
  endtask

  task automatic test_r0();
    step();
    req = 4'b0100;
    addr[14:10] = 5'd0;
    #1;
    total_cnt++;
    if (bus_a.gnt !== 4'b0100) $display("FAIL r0_gnt got %b required 0100", bus_a.gnt);
    else pass_cnt++;
    push_read(2, 5'd0);
    step();
    req = '0;
    step();
    total_cnt++;
    if (bus_a.rd_valid !== 1'b1 || bus_a.rd_data !== 32'h0)
      $display("FAIL r0_zero v=%b data=%h required 1/00000000", bus_a.rd_valid, bus_a.rd_data);
    else pass_cnt++;
    total_cnt++;
    if (bus_b.rd_valid !== 1'b1 || bus_b.rd_data !== 32'hFFFFFFFF)
      $display("FAIL r0_raw v=%b data=%h required 1/ffffffff", bus_b.rd_valid, bus_b.rd_data);
    else pass_cnt++;
    drain("r0");
  endtask

  task automatic test_hold();
    do_reset();
    for (int i = 0; i < 4; i++) addr[i*5 +: 5] = 5'(i + 1);
    step();
    req  = 4'hF;
    hold = 1'b0;
    #1;
    total_cnt++;
    if (bus_a.gnt !== 4'b0001) $display("FAIL hold_first_gnt got %b required 0001", bus_a.gnt);
    else pass_cnt++;
    push_read(0, 5'd1);
    for (int c = 1; c <= 3; c++) begin
      step();
      hold = 1'b1;
      #1;
      total_cnt++;
      if (bus_a.gnt !== 4'b0 || bus_a.sel !== 5'd1)
        $display("FAIL hold_block c=%0d gnt=%b sel=%0d required 0000/1", c, bus_a.gnt, bus_a.sel);
      else pass_cnt++;
      if (c == 2) begin
        total_cnt++;
        if (bus_a.rd_valid !== 1'b1 || bus_a.rd_id !== 2'd0)
          $display("FAIL hold_inflight v=%b id=%0d required 1/0", bus_a.rd_valid, bus_a.rd_id);
        else pass_cnt++;
      end
    end
    step();
    hold = 1'b0;
    #1;
    total_cnt++;
    if (bus_a.gnt !== 4'b0010) $display("FAIL hold_ptr gnt=%b required 0010", bus_a.gnt);
    else pass_cnt++;
    push_read(1, 5'd2);
    step();
    req = '0;
    drain("hold");
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_g;
    int win;
    int j;
    do_reset();
    model_ptr = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      req  = 4'($urandom_range(0, 15));
      hold = ($urandom_range(0, 3) == 0);
      addr = 20'($urandom);
      #1;
      win = -1;
      for (int k = 0; k < 4; k++) begin
        j = (model_ptr + k) % 4;
        if (win < 0 && req[j]) win = j;
      end
      exp_g = (hold || win < 0) ? 4'b0 : (4'b0001 << win);
      total_cnt++;
      if (bus_a.gnt !== exp_g)
        $display("FAIL b2b_gnt c=%0d req=%b hold=%b got %b required %b", c, req, hold, bus_a.gnt, exp_g);
      else pass_cnt++;
      if (exp_g != 4'b0) begin
        push_read(win, addr[win*5 +: 5]);
        model_ptr = (win + 1) % 4;
      end
    end
    step();
    req  = '0;
    hold = 1'b0;
    drain("b2b");
  endtask

  task automatic test_reset_midflight();
    step();
    req = 4'b0010;
    hold = 1'b0;
    #1;
    total_cnt++;
    if (bus_a.gnt !== 4'b0010) $display("FAIL midflight_gnt got %b required 0010", bus_a.gnt);
    else pass_cnt++;
    step();
    req   = '0;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (bus_a.sel !== 5'd0 || bus_a.rd_valid !== 1'b0)
      $display("FAIL midflight_clear sel=%0d v=%b required 0/0", bus_a.sel, bus_a.rd_valid);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus_a.rd_valid !== 1'b0) $display("FAIL midflight_drop v=%b required 0", bus_a.rd_valid);
    else pass_cnt++;
    rst_n = 1'b1;
    step();
    req = 4'hF;
    #1;
    total_cnt++;
    if (bus_a.gnt !== 4'b0001) $display("FAIL midflight_ptr gnt=%b required 0001", bus_a.gnt);
    else pass_cnt++;
    push_read(0, addr[4:0]);
    step();
    req = '0;
    drain("midflight");
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst_n = 1'b0;
    req   = '0;
    hold  = 1'b0;
    addr  = '0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'hFFFFFFFF;
    rf[5] = 32'hDEADBEEF;
    test_reset();
    test_fairness();
    test_single();
    test_r0();
    test_hold();
    test_back_to_back();
    test_reset_midflight();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached passed=%0d total=%0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule
